// File: rtl/hold_sequencer_pkg.sv
// Shared hold/flush encodings for the hold sequencer.
// Hold levels, address width and sequencer states.
package hold_sequencer_pkg;

  localparam int HOLD_FLAG_W = 3;
  localparam int INST_ADDR_W = 32;

  localparam logic HOLD_ENABLE = 1'b1;
  localparam logic JUMP_ENABLE = 1'b1;

  typedef enum logic [HOLD_FLAG_W-1:0] {
    HOLD_NONE = 3'b000,
    HOLD_PC   = 3'b001,
    HOLD_IF   = 3'b010,
    HOLD_ID   = 3'b011
  } hold_flag_e;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_FLUSH  = 2'd1,
    HS_DRAIN  = 2'd2,
    HS_HALTED = 2'd3
  } hs_state_e;

endpackage

// File: rtl/hold_sequencer_sat_counter.sv
// Saturating run-length counter with a one-shot hit pulse.
// The pulse re-arms only once the run is cleared.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             hit_pulse
);

  logic at_limit;
  logic fired;

  assign at_limit = (cnt == WIDTH'(LIMIT));

  // count the run, fire once the cycle after reaching the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fired     <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= at_limit && !fired;
      if (clr) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (inc && !at_limit)
          cnt <= cnt + WIDTH'(1);
        if (at_limit)
          fired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hold_sequencer.sv
// Pipeline hold/flush arbiter with jump flush extension,
// JTAG drain/halt handshake, bus-stall watchdog, hold counter.
module hold_sequencer
  import hold_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_LIMIT  = 255,
  parameter int STALL_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_flag_if_i,
  input  logic                   jump_flag_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   hold_flag_ex_i,
  input  logic                   hold_flag_rib_i,
  input  logic                   hold_flag_clint_i,
  input  logic                   jtag_halt_req_i,
  output logic [HOLD_FLAG_W-1:0] hold_flag_o,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic                   jtag_halted_o,
  output logic                   stall_timeout_o,
  output logic [31:0]            hold_cycles_o
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int QW = $clog2(DRAIN_CYCLES + 1);

  hs_state_e     state;
  hs_state_e     state_nxt;
  hold_flag_e    hold;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_nxt;
  logic [QW-1:0] quiet_cnt;
  logic [QW-1:0] quiet_nxt;
  logic          hard;
  logic          noisy;
  logic          stall_inc;
  logic [STALL_W-1:0] stall_cnt;

  assign hard  = jump_flag_i | hold_flag_ex_i
               | hold_flag_clint_i | hold_flag_if_i;
  assign noisy = jump_flag_i | hold_flag_ex_i
               | hold_flag_clint_i | hold_flag_rib_i;

  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;
  assign hold_flag_o = hold;

  // state, flush and drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HS_RUN;
      flush_cnt     <= '0;
      quiet_cnt     <= '0;
      jtag_halted_o <= 1'b0;
      hold_cycles_o <= '0;
    end else begin
      state         <= state_nxt;
      flush_cnt     <= flush_nxt;
      quiet_cnt     <= quiet_nxt;
      jtag_halted_o <= (state_nxt == HS_HALTED);
      hold_cycles_o <= hold_cycles_o
                     + 32'(hold != HOLD_NONE);
    end
  end

  // next state and hold level
  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    quiet_nxt = quiet_cnt;
    hold      = HOLD_NONE;
    case (state)
      HS_RUN: begin
        if (hard)
          hold = HOLD_ID;
        else if (hold_flag_rib_i)
          hold = HOLD_PC;
        if (jump_flag_i && FLUSH_CYCLES > 1) begin
          state_nxt = HS_FLUSH;
          flush_nxt = FW'(FLUSH_CYCLES - 1);
        end else if (jtag_halt_req_i) begin
          state_nxt = HS_DRAIN;
          quiet_nxt = '0;
        end
      end
      HS_FLUSH: begin
        hold = HOLD_ID;
        if (jump_flag_i) begin
          flush_nxt = FW'(FLUSH_CYCLES - 1);
        end else if (flush_cnt == FW'(1)) begin
          flush_nxt = '0;
          quiet_nxt = '0;
          state_nxt = jtag_halt_req_i ? HS_DRAIN : HS_RUN;
        end else begin
          flush_nxt = flush_cnt - FW'(1);
        end
      end
      HS_DRAIN: begin
        hold = hard ? HOLD_ID : HOLD_PC;
        if (!jtag_halt_req_i)
          state_nxt = HS_RUN;
        else if (noisy)
          quiet_nxt = '0;
        else if (quiet_cnt == QW'(DRAIN_CYCLES - 1))
          state_nxt = HS_HALTED;
        else
          quiet_nxt = quiet_cnt + QW'(1);
      end
      HS_HALTED: begin
        hold = HOLD_ID;
        if (!jtag_halt_req_i)
          state_nxt = HS_RUN;
      end
      default: state_nxt = HS_RUN;
    endcase
  end

  assign stall_inc = hold_flag_rib_i
                   && (state == HS_RUN || state == HS_DRAIN);

  sat_counter #(
    .WIDTH (STALL_W),
    .LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk       (clk),
    .rst       (rst),
    .inc       (stall_inc),
    .clr       (!stall_inc),
    .cnt       (stall_cnt),
    .hit_pulse (stall_timeout_o)
  );

endmodule

// File: tb/tb_hold_sequencer.sv
// Directed and random bench for hold_sequencer.
// Reference model tracks flush/drain/halt as plain counters.
module tb_hold_sequencer;

  localparam int FC = 2;
  localparam int DC = 3;
  localparam int SL = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifq, jmp, ex, rib, clint, req;
  logic [31:0] addr;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        jtag_halted_o;
  logic        stall_timeout_o;
  logic [31:0] hold_cycles_o;

  int errors = 0;
  int checks = 0;

  int          flush_left = 0;
  int          quiet = 0;
  bit          draining = 0;
  bit          halted = 0;
  int          run_len = 0;
  bit          exp_to = 0;
  logic [31:0] exp_hc = 0;

  always #5 clk = ~clk;

  hold_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .hold_flag_if_i    (ifq),
    .jump_flag_i       (jmp),
    .jump_addr_i       (addr),
    .hold_flag_ex_i    (ex),
    .hold_flag_rib_i   (rib),
    .hold_flag_clint_i (clint),
    .jtag_halt_req_i   (req),
    .hold_flag_o       (hold_flag_o),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o),
    .jtag_halted_o     (jtag_halted_o),
    .stall_timeout_o   (stall_timeout_o),
    .hold_cycles_o     (hold_cycles_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [2:0] eh;
    bit hard, elig;
    #1;
    hard = jmp | ex | clint | ifq;
    if (halted || flush_left > 0) eh = 3'd3;
    else if (draining) eh = hard ? 3'd3 : 3'd1;
    else eh = hard ? 3'd3 : (rib ? 3'd1 : 3'd0);
    chk("hold_flag", 32'(hold_flag_o), 32'(eh));
    chk("jump_flag", 32'(jump_flag_o), 32'(jmp));
    chk("jump_addr", jump_addr_o, addr);
    elig = rib && !halted && flush_left == 0;
    if (rst) begin
      flush_left = 0; quiet = 0;
      draining = 0; halted = 0;
      run_len = 0; exp_to = 0; exp_hc = 0;
    end else begin
      exp_to = (run_len == SL);
      run_len = elig ? run_len + 1 : 0;
      exp_hc = exp_hc + 32'(eh != 0);
      if (halted) begin
        if (!req) halted = 0;
      end else if (flush_left > 0) begin
        if (jmp) flush_left = FC - 1;
        else if (flush_left == 1) begin
          flush_left = 0;
          if (req) begin draining = 1; quiet = 0; end
        end else flush_left--;
      end else if (draining) begin
        if (!req) draining = 0;
        else if (jmp | ex | clint | rib) quiet = 0;
        else if (quiet == DC - 1) begin
          draining = 0; halted = 1;
        end else quiet++;
      end else begin
        if (jmp && FC > 1) flush_left = FC - 1;
        else if (req) begin draining = 1; quiet = 0; end
      end
    end
    @(posedge clk);
    #1;
    chk("jtag_halted", 32'(jtag_halted_o), 32'(halted));
    chk("stall_timeout", 32'(stall_timeout_o), 32'(exp_to));
    chk("hold_cycles", hold_cycles_o, exp_hc);
  endtask

  task automatic idle();
    ifq = 0; jmp = 0; ex = 0; rib = 0;
    clint = 0; req = 0; addr = 0;
  endtask

  initial begin
    int pulses, at;
    rst = 1; idle();
    cycle(); cycle();
    rst = 0;

    // 1: idle
    repeat (10) cycle();
    chk("t1_hc", hold_cycles_o, 32'd0);
    chk("t1_halted", 32'(jtag_halted_o), 32'd0);

    // 2: single jump
    jmp = 1; addr = 32'h100;
    cycle();
    jmp = 0; addr = 0;
    cycle(); cycle(); cycle();
    chk("t2_hc", hold_cycles_o, 32'd2);

    // 3: back-to-back jump after reset
    rst = 1; cycle(); rst = 0;
    jmp = 1; addr = 32'h200; cycle();
    addr = 32'h240; cycle();
    jmp = 0; addr = 0;
    cycle(); cycle(); cycle();
    chk("t3_hc", hold_cycles_o, 32'd3);

    // 4: halt while bus busy, then resume
    req = 1; rib = 1;
    cycle(); cycle();
    rib = 0;
    cycle(); cycle();
    chk("t4_not_yet", 32'(jtag_halted_o), 32'd0);
    cycle();
    chk("t4_halted", 32'(jtag_halted_o), 32'd1);
    cycle(); cycle();
    req = 0; cycle();
    chk("t4_resumed", 32'(jtag_halted_o), 32'd0);
    cycle();
    chk("t4_hold_none", 32'(hold_flag_o), 32'd0);

    // 6: reset in DRAIN and in HALTED
    req = 1; cycle(); cycle();
    rst = 1; cycle(); rst = 0;
    chk("t6a_hc", hold_cycles_o, 32'd0);
    chk("t6a_halted", 32'(jtag_halted_o), 32'd0);
    repeat (5) cycle();
    chk("t6b_pre", 32'(jtag_halted_o), 32'd1);
    rst = 1; cycle(); rst = 0;
    chk("t6b_halted", 32'(jtag_halted_o), 32'd0);
    chk("t6b_hc", hold_cycles_o, 32'd0);
    idle(); cycle(); cycle();

    // 5: long bus stall
    rib = 1; pulses = 0; at = -1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (stall_timeout_o) begin
        pulses++;
        at = i;
      end
    end
    chk("t5_pulses", 32'(pulses), 32'd1);
    chk("t5_at", 32'(at), 32'd255);
    rib = 0; cycle(); cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      jmp   = ($urandom % 10) == 0;
      addr  = $urandom;
      ex    = ($urandom % 8) == 0;
      clint = ($urandom % 16) == 0;
      ifq   = ($urandom % 10) == 0;
      if (($urandom % 8) == 0) rib = ~rib;
      if (($urandom % 40) == 0) req = ~req;
      rst   = ($urandom % 200) == 0;
      cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
